// File: rtl/adc_responder_if.sv
// Parallel ADC handshake bundle: convst/eoc/cs/rd plus the result bus and error pulses.
// The sampler side uses the master modport; the emulated ADC uses the slave modport.
interface adc_responder_if;
   logic [2:0] chnl;
   logic       n_convst;
   logic       n_cs;
   logic       n_rd;
   logic       n_eoc;
   logic [7:0] adc_out;
   logic       adc_oe;
   logic       conv_err;
   logic       rd_err;

   modport master (
      output chnl, n_convst, n_cs, n_rd,
      input  n_eoc, adc_out, adc_oe, conv_err, rd_err
   );

   modport slave (
      input  chnl, n_convst, n_cs, n_rd,
      output n_eoc, adc_out, adc_oe, conv_err, rd_err
   );
endinterface

// File: rtl/adc_responder.sv
// Emulated 8-bit 8-channel parallel ADC: channel c returns a triangle wave lagging ch0 by c*CH_DELAY samples.
// Optional ADC_RESP_NOISE_EN adds saturating LFSR noise (-4..+3) to each conversion result.
//
// state   | meaning
// IDLE    | waiting for a convst fall
// CONVERT | counting CONV_CYCLES, result not yet valid
// READY   | result valid, n_eoc low
// READ    | result driven on adc_out until cs/rd release
module adc_responder #(
   parameter int CONV_CYCLES = 20,
   parameter int CH_DELAY    = 3,
   parameter int STEP        = 4,
   parameter int NUM_CH      = 4
) (
   input  logic            clk,
   input  logic            n_reset,
   adc_responder_if.slave  bus
);

   localparam int         CW    = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CONV_CYCLES - 1);
   localparam logic [8:0] STEP9 = 9'(STEP);
   localparam logic [8:0] LAG9  = 9'(CH_DELAY * STEP);

   typedef enum logic [1:0] {IDLE, CONVERT, READY, READ} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    chnl_q;
   logic [2:0]    chnl_l;
   logic          convst_q;
   logic          convst_qq;
   logic          cs_q;
   logic          rd_q;
   logic          rd_act_q;
   logic [8:0]    idx;
   logic [7:0]    result;
   logic          n_eoc;
   logic [7:0]    adc_out;
   logic          adc_oe;
   logic          conv_err;
   logic          rd_err;

   logic          convst_fall;
   logic          rd_act;
   logic          rd_start;
   logic          conv_done;
   logic [8:0]    phase;
   logic [7:0]    clean;
   logic [7:0]    value;

   assign convst_fall = convst_qq & ~convst_q;
   assign rd_act      = ~cs_q & ~rd_q;
   assign rd_start    = rd_act & ~rd_act_q;
   assign conv_done   = (state == CONVERT) && (cnt == LAST);

   always_comb begin
      phase = idx * STEP9 - 9'(chnl_l) * LAG9;
      clean = phase[8] ? ~phase[7:0] : phase[7:0];
      if (int'(chnl_l) >= NUM_CH) clean = 8'h80;
   end

`ifdef ADC_RESP_NOISE_EN
   logic [7:0]        lfsr;
   logic signed [9:0] noisy;

   always_comb begin
      noisy = $signed({2'b00, clean}) + $signed({{7{lfsr[2]}}, lfsr[2:0]});
      if (noisy < 0)
         value = 8'h00;
      else if (noisy > 10'sd255)
         value = 8'hFF;
      else
         value = noisy[7:0];
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         lfsr <= 8'h5A;
      else if (conv_done)
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
`else
   assign value = clean;
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         chnl_q    <= '0;
         chnl_l    <= '0;
         convst_q  <= 1'b1;
         convst_qq <= 1'b1;
         cs_q      <= 1'b1;
         rd_q      <= 1'b1;
         rd_act_q  <= 1'b0;
         idx       <= '0;
         result    <= '0;
         n_eoc     <= 1'b1;
         adc_out   <= '0;
         adc_oe    <= 1'b0;
         conv_err  <= 1'b0;
         rd_err    <= 1'b0;
      end else begin
         convst_q  <= bus.n_convst;
         convst_qq <= convst_q;
         cs_q      <= bus.n_cs;
         rd_q      <= bus.n_rd;
         chnl_q    <= bus.chnl;
         rd_act_q  <= rd_act;
         conv_err  <= 1'b0;
         rd_err    <= 1'b0;
         adc_oe    <= rd_act;
         // Reads outside READY still drive the last result, flagged by rd_err.
         if (rd_act)
            adc_out <= result;
         if (rd_start && (state == IDLE || state == CONVERT))
            rd_err <= 1'b1;

         case (state)
            IDLE: begin
               if (convst_fall) begin
                  state  <= CONVERT;
                  chnl_l <= chnl_q;
                  cnt    <= '0;
               end
            end
            CONVERT: begin
               if (convst_fall)
                  conv_err <= 1'b1;
               if (cnt == LAST) begin
                  state  <= READY;
                  result <= value;
                  n_eoc  <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            READY: begin
               if (convst_fall) begin
                  state  <= CONVERT;
                  chnl_l <= chnl_q;
                  cnt    <= '0;
                  n_eoc  <= 1'b1;
               end else if (rd_act) begin
                  state <= READ;
               end
            end
            READ: begin
               if (!rd_act) begin
                  state <= IDLE;
                  n_eoc <= 1'b1;
                  if (chnl_l == 3'd0)
                     idx <= idx + 9'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.n_eoc    = n_eoc;
   assign bus.adc_out  = adc_out;
   assign bus.adc_oe   = adc_oe;
   assign bus.conv_err = conv_err;
   assign bus.rd_err   = rd_err;

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: latency, waveform values per channel/idx, error pulses, async reset.
module tb_adc_responder;
   logic clk;
   logic n_reset;
   int   total;
   int   bad;

   adc_responder_if bus ();

   adc_responder dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      #2 n_reset = 1'b0;
      #10 n_reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // lat = edges after the first edge that samples n_convst low, -1 on timeout
   task automatic do_conv(input logic [2:0] ch, input int second_at, output int lat, output int cerr);
      bus.chnl     = ch;
      bus.n_convst = 1'b0;
      lat  = -1;
      cerr = 0;
      @(posedge clk); #1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (bus.conv_err) cerr++;
         if (n == 2) bus.n_convst = 1'b1;
         if (second_at > 0 && n == second_at) bus.n_convst = 1'b0;
         if (second_at > 0 && n == second_at + 2) bus.n_convst = 1'b1;
         if (bus.n_eoc == 1'b0) begin
            lat = n;
            break;
         end
      end
      bus.n_convst = 1'b1;
   endtask

   task automatic do_read(output logic [7:0] v, output logic oe, output logic rerr);
      bus.n_cs = 1'b0;
      bus.n_rd = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      v    = bus.adc_out;
      oe   = bus.adc_oe;
      rerr = bus.rd_err;
      bus.n_rd = 1'b1;
      bus.n_cs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic conv_read(input logic [2:0] ch, output logic [7:0] v);
      int   lat, cerr;
      logic oe, rerr;
      do_conv(ch, 0, lat, cerr);
      if (lat < 0) chk("eoc_timeout", 32'(lat), 32'd21);
      do_read(v, oe, rerr);
   endtask

   initial begin
      int         lat, cerr;
      logic [7:0] v;
      logic       oe, rerr;
      logic [7:0] exp_ch0 [3];

      total = 0;
      bad   = 0;
      exp_ch0[0] = 8'd0;
      exp_ch0[1] = 8'd4;
      exp_ch0[2] = 8'd8;
      n_reset      = 1'b0;
      bus.chnl     = 3'd0;
      bus.n_convst = 1'b1;
      bus.n_cs     = 1'b1;
      bus.n_rd     = 1'b1;
      #23;
      chk("rst_n_eoc", 32'(bus.n_eoc), 32'd1);
      chk("rst_adc_out", 32'(bus.adc_out), 32'd0);
      chk("rst_adc_oe", 32'(bus.adc_oe), 32'd0);
      chk("rst_conv_err", 32'(bus.conv_err), 32'd0);
      chk("rst_rd_err", 32'(bus.rd_err), 32'd0);
      n_reset = 1'b1;
      @(posedge clk); #1;

      // 1: ch0 latency and first read
      do_conv(3'd0, 0, lat, cerr);
      chk("t1_latency", 32'(lat), 32'd21);
      chk("t1_conv_err", 32'(cerr), 32'd0);
      do_read(v, oe, rerr);
      chk("t1_value", 32'(v), 32'h00);
      chk("t1_oe", 32'(oe), 32'd1);
      chk("t1_rd_err", 32'(rerr), 32'd0);
      chk("t1_eoc_after", 32'(bus.n_eoc), 32'd1);

      // 2: ch1 at idx0, then three ch0 reads, then ch1 at idx3
      do_reset();
      conv_read(3'd1, v);
      chk("t2_ch1_idx0", 32'(v), 32'd11);
      for (int i = 0; i < 3; i++) begin
         conv_read(3'd0, v);
         chk("t2_ch0_seq", 32'(v), 32'(exp_ch0[i]));
      end
      conv_read(3'd1, v);
      chk("t2_ch1_idx3", 32'(v), 32'h00);

      // 3: ch5 is constant mid-scale and leaves idx alone
      conv_read(3'd5, v);
      chk("t3_ch5", 32'(v), 32'h80);
      conv_read(3'd0, v);
      chk("t3_ch0_idx3", 32'(v), 32'd12);

      // 4: second convst during CONVERT
      do_conv(3'd2, 5, lat, cerr);
      chk("t4_latency", 32'(lat), 32'd21);
      chk("t4_conv_err", 32'(cerr), 32'd1);
      do_read(v, oe, rerr);
      chk("t4_ch2_idx4", 32'(v), 32'd7);

      // read while IDLE: previous result, rd_err, no state change
      do_read(v, oe, rerr);
      chk("idle_rd_value", 32'(v), 32'd7);
      chk("idle_rd_oe", 32'(oe), 32'd1);
      chk("idle_rd_err", 32'(rerr), 32'd1);
      chk("idle_rd_eoc", 32'(bus.n_eoc), 32'd1);

      // 5: sweep 128 ch0 samples, wrap back to 0
      do_reset();
      for (int i = 0; i < 128; i++) begin
         conv_read(3'd0, v);
         if (i == 63) chk("t5_peak_idx63", 32'(v), 32'd252);
         if (i == 64) chk("t5_idx64", 32'(v), 32'd255);
      end
      conv_read(3'd0, v);
      chk("t5_idx128", 32'(v), 32'h00);

      // 6: reset in the middle of READ
      do_conv(3'd0, 0, lat, cerr);
      chk("t6_latency", 32'(lat), 32'd21);
      bus.n_cs = 1'b0;
      bus.n_rd = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t6_oe_before", 32'(bus.adc_oe), 32'd1);
      #2 n_reset = 1'b0;
      #1;
      chk("t6_oe_async", 32'(bus.adc_oe), 32'd0);
      chk("t6_eoc_async", 32'(bus.n_eoc), 32'd1);
      chk("t6_out_async", 32'(bus.adc_out), 32'd0);
      bus.n_cs = 1'b1;
      bus.n_rd = 1'b1;
      #4 n_reset = 1'b1;
      @(posedge clk); #1;
      conv_read(3'd0, v);
      chk("t6_ch0_after", 32'(v), 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
